// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM state type, RV32I load/store funct3 encodings and access-size helper
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  function automatic logic [2:0] size_of(input logic [2:0] f3);
    return f3[1:0] == 2'b00 ? 3'd1 : f3[1:0] == 2'b01 ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane masks, lane-shifted store words and extended load result for one access
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [3:0]  bmask0,
  output logic [3:0]  bmask1,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  output logic [31:0] rdata
);
  logic [7:0]  mask;
  logic [31:0] raw;
  always_comb begin
    mask   = ((8'd1 << size_of(funct3)) - 8'd1) << off;
    bmask0 = mask[3:0];
    bmask1 = mask[7:4];
    wdata0 = wdata << {off, 3'b000};
    wdata1 = wdata >> (6'd32 - {1'b0, off, 3'b000});
    raw    = 32'({hi, lo} >> {off, 3'b000});
    rdata  = funct3 == F3_B  ? {{24{raw[7]}}, raw[7:0]} :
             funct3 == F3_H  ? {{16{raw[15]}}, raw[15:0]} :
             funct3 == F3_BU ? {24'd0, raw[7:0]} :
             funct3 == F3_HU ? {16'd0, raw[15:0]} : raw;
  end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding RV32I load/store initiator; splits word-crossing accesses in two
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W        = 12,
  parameter bit MISALIGNED_EN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_store,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  output logic        o_mem_wren,
  input  logic [31:0] i_mem_rdata,
  output logic        o_rsp_valid,
  output logic        o_rsp_err,
  output logic [31:0] o_rsp_rdata
);
  state_t             state, state_nx;
  logic               store_q, err_q;
  logic [2:0]         f3_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q, lo_q, hi_q;
  logic [2:0]         req_size;
  logic               req_split, req_err, accept, split_q, acc0, acc1, resp;
  logic [ADDR_W-3:0]  widx1;
  logic [3:0]         bm0, bm1;
  logic [31:0]        wd0, wd1, ld;
  lsu_align u_align (
    .funct3(f3_q), .off(addr_q[1:0]), .wdata(wdata_q), .hi(hi_q), .lo(lo_q),
    .bmask0(bm0), .bmask1(bm1), .wdata0(wd0), .wdata1(wd1), .rdata(ld)
  );
  always_comb begin
    req_size  = size_of(i_req_funct3);
    req_split = ({1'b0, i_req_addr[1:0]} + req_size) > 3'd4;
    req_err   = (i_req_store ? i_req_funct3[2] : (i_req_funct3[1:0] == 2'b11 || i_req_funct3[2:1] == 2'b11))
              | (|i_req_addr[31:ADDR_W])
              | (MISALIGNED_EN ? (req_split && &i_req_addr[ADDR_W-1:2])
                               : |(i_req_addr[1:0] & 2'(req_size - 3'd1)));
    o_req_ready = state == IDLE;
    accept   = i_req_valid & o_req_ready;
    split_q  = ({1'b0, addr_q[1:0]} + size_of(f3_q)) > 3'd4;
    acc0     = state == ACC0;
    acc1     = state == ACC1;
    resp     = state == RESP;
    state_nx = state == IDLE ? (accept ? (req_err ? RESP : ACC0) : IDLE) :
               acc0 ? (split_q ? ACC1 : RESP) :
               acc1 ? RESP : IDLE;
    widx1       = addr_q[ADDR_W-1:2] + (ADDR_W-2)'(1);
    o_mem_addr  = acc0 ? 32'({addr_q[ADDR_W-1:2], 2'b00}) : acc1 ? 32'({widx1, 2'b00}) : '0;
    o_mem_bmask = acc0 ? bm0 : acc1 ? bm1 : 4'b0000;
    o_mem_wdata = acc0 ? wd0 : acc1 ? wd1 : '0;
    // a write coinciding with an asserted reset edge is dropped, so an aborted split keeps its second word
    o_mem_wren  = (acc0 | acc1) & store_q & i_reset_n;
    o_rsp_valid = resp;
    o_rsp_err   = resp & err_q;
    o_rsp_rdata = (resp & ~err_q & ~store_q) ? ld : '0;
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state <= IDLE;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        store_q <= i_req_store;
        f3_q    <= i_req_funct3;
        addr_q  <= i_req_addr[ADDR_W-1:0];
        wdata_q <= i_req_wdata;
        err_q   <= req_err;
        hi_q    <= '0;
      end
      if (acc0) lo_q <= i_mem_rdata;
      if (acc1) hi_q <= i_mem_rdata;
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed scoreboard bench for lsu_ctrl against a byte-masked word memory model
module tb_lsu_ctrl;
  logic        clk = 1'b0, reset_n = 1'b0, clr = 1'b1;
  logic        req_valid = 1'b0, na_valid = 1'b0, req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, mem_wren, rsp_valid, rsp_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, rsp_rdata;
  logic [3:0]  mem_bmask;
  logic        na_ready, na_wren, na_rsp_valid, na_rsp_err;
  logic [31:0] na_addr, na_wdata, na_rdata_in, na_rsp_rdata;
  logic [3:0]  na_bmask;
  logic [31:0] mem [1024];
  int          checks = 0, errors = 0, cyc = 0;
  typedef struct {
    string       tag;
    logic        err;
    logic [31:0] rd;
    int          lat;
    int          t;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lsu_ctrl dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_store(req_store), .i_req_funct3(req_funct3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_bmask(mem_bmask), .o_mem_wren(mem_wren),
    .i_mem_rdata(mem_rdata), .o_rsp_valid(rsp_valid), .o_rsp_err(rsp_err), .o_rsp_rdata(rsp_rdata)
  );
  lsu_ctrl #(.ADDR_W(12), .MISALIGNED_EN(1'b0)) dut_na (
    .i_clk(clk), .i_reset_n(reset_n), .i_req_valid(na_valid), .o_req_ready(na_ready),
    .i_req_store(req_store), .i_req_funct3(req_funct3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_mem_addr(na_addr), .o_mem_wdata(na_wdata), .o_mem_bmask(na_bmask), .o_mem_wren(na_wren),
    .i_mem_rdata(na_rdata_in), .o_rsp_valid(na_rsp_valid), .o_rsp_err(na_rsp_err), .o_rsp_rdata(na_rsp_rdata)
  );

  assign mem_rdata   = mem[mem_addr[11:2]];
  assign na_rdata_in = mem[na_addr[11:2]];
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    end else if (mem_wren) begin
      for (int b = 0; b < 4; b++)
        if (mem_bmask[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // called at a negedge with the DUT idle; returns at the negedge of the first cycle after acceptance
  task automatic send(input string tag, input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd, input int e_lat);
    exp_t e;
    chk({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_funct3 = 3'b111; req_addr = 32'hFFFF_FFFC; req_wdata = ~wd;
    e.tag = tag; e.err = e_err; e.rd = e_rd; e.lat = e_lat; e.t = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_rsp();
    exp_t e;
    int   k = 0;
    while (rsp_valid !== 1'b1 && k < 8) begin
      @(negedge clk);
      k++;
    end
    e = sb.pop_front();
    chk({e.tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({e.tag, " latency"}, 32'(cyc - e.t + 1), 32'(e.lat));
    chk({e.tag, " rsp_err"}, 32'(rsp_err), 32'(e.err));
    chk({e.tag, " rsp_rdata"}, rsp_rdata, e.rd);
    @(negedge clk);
    chk({e.tag, " pulse_end"}, {30'd0, rsp_valid, rsp_err} | rsp_rdata, 32'd0);
  endtask

  task automatic acc(input string tag, input logic [31:0] a, input logic [3:0] bm, input logic we, input logic [31:0] wd);
    chk({tag, " mem_addr"}, mem_addr, a);
    chk({tag, " mem_bmask"}, 32'(mem_bmask), 32'(bm));
    chk({tag, " mem_wren"}, 32'(mem_wren), 32'(we));
    if (we) chk({tag, " mem_wdata"}, mem_wdata, wd);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ready", 32'(req_ready), 32'd1);
    chk("reset rsp", {30'd0, rsp_valid, rsp_err} | rsp_rdata, 32'd0);
    chk("reset mem", mem_addr | {27'd0, mem_wren, mem_bmask}, 32'd0);
    reset_n = 1'b1; clr = 1'b0;

    send("sw", 1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 1'b0, 32'h0, 2);
    acc("sw acc0", 32'h010, 4'b1111, 1'b1, 32'hDEADBEEF);
    wait_rsp();
    send("lw", 1'b0, 3'b010, 32'h010, 32'h0, 1'b0, 32'hDEADBEEF, 2);
    acc("lw acc0", 32'h010, 4'b1111, 1'b0, 32'h0);
    wait_rsp();

    send("sb", 1'b1, 3'b000, 32'h023, 32'h000000A5, 1'b0, 32'h0, 2);
    acc("sb acc0", 32'h020, 4'b1000, 1'b1, 32'hA5000000);
    wait_rsp();
    send("lb", 1'b0, 3'b000, 32'h023, 32'h0, 1'b0, 32'hFFFFFFA5, 2);
    wait_rsp();
    send("lbu", 1'b0, 3'b100, 32'h023, 32'h0, 1'b0, 32'h000000A5, 2);
    wait_rsp();

    send("sh split", 1'b1, 3'b001, 32'h007, 32'h00001234, 1'b0, 32'h0, 3);
    acc("sh acc0", 32'h004, 4'b1000, 1'b1, 32'h34000000);
    @(negedge clk);
    acc("sh acc1", 32'h008, 4'b0001, 1'b1, 32'h00000012);
    wait_rsp();
    send("lhu split", 1'b0, 3'b101, 32'h007, 32'h0, 1'b0, 32'h00001234, 3);
    wait_rsp();
    send("lw split", 1'b0, 3'b010, 32'h011, 32'h0, 1'b0, 32'h00DEADBE, 3);
    wait_rsp();
    send("lb byte3", 1'b0, 3'b000, 32'h013, 32'h0, 1'b0, 32'hFFFFFFDE, 2);
    wait_rsp();

    send("lw range", 1'b0, 3'b010, 32'h1000, 32'h0, 1'b1, 32'h0, 1);
    acc("lw range idle", 32'h0, 4'b0000, 1'b0, 32'h0);
    wait_rsp();
    send("lw top", 1'b0, 3'b010, 32'hFFE, 32'h0, 1'b1, 32'h0, 1);
    acc("lw top idle", 32'h0, 4'b0000, 1'b0, 32'h0);
    wait_rsp();
    send("ld f3", 1'b0, 3'b011, 32'h010, 32'h0, 1'b1, 32'h0, 1);
    wait_rsp();
    send("st f3", 1'b1, 3'b100, 32'h010, 32'h0, 1'b1, 32'h0, 1);
    acc("st f3 idle", 32'h0, 4'b0000, 1'b0, 32'h0);
    wait_rsp();

    send("sw w0", 1'b1, 3'b010, 32'h000, 32'h8BADF00D, 1'b0, 32'h0, 2);
    wait_rsp();
    send("lh mis", 1'b0, 3'b001, 32'h001, 32'h0, 1'b0, 32'hFFFFADF0, 2);
    wait_rsp();
    na_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b001; req_addr = 32'h001;
    @(negedge clk);
    na_valid = 1'b0;
    chk("na lh valid", 32'(na_rsp_valid), 32'd1);
    chk("na lh err", 32'(na_rsp_err), 32'd1);
    chk("na lh rdata", na_rsp_rdata, 32'd0);
    @(negedge clk);

    send("sw abort", 1'b1, 3'b010, 32'h042, 32'hCAFEBABE, 1'b0, 32'h0, 3);
    sb.delete();
    acc("abort acc0", 32'h040, 4'b1100, 1'b1, 32'hBABE0000);
    @(negedge clk);
    chk("abort acc1 addr", mem_addr, 32'h044);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("abort ready", 32'(req_ready), 32'd1);
    chk("abort no rsp", 32'(rsp_valid), 32'd0);
    chk("abort word0", mem[16], 32'hBABE0000);
    chk("abort word1", mem[17], 32'h0);
    @(negedge clk);
    chk("abort no rsp later", 32'(rsp_valid), 32'd0);
    send("lw after", 1'b0, 3'b010, 32'h040, 32'h0, 1'b0, 32'hBABE0000, 2);
    wait_rsp();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store initiator in front of the word-addressed data memory (async read, sync byte-masked write, 1024 x 32).
- Takes one RV32I load/store request at a time from the execute stage and generates word address, shifted write data and byte mask.
- Splits word-crossing accesses into two word accesses.
- Returns a sign- or zero-extended load result, or an error, through a one-cycle response pulse.

Parameters:
ADDR_W, 12, byte-address bits covered by data memory (4 KiB); higher address bits must be zero
MISALIGNED_EN, 1, 1 = split word-crossing accesses; 0 = any misaligned access returns error, no memory access

Ports:
i_clk  in  1  clock
i_reset_n  in  1  synchronous active-low reset
i_req_valid  in  1  request present
o_req_ready  out  1  high only in IDLE
i_req_store  in  1  1 = store, 0 = load
i_req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW)
i_req_addr  in  32  byte address
i_req_wdata  in  32  store data, right-aligned
o_mem_addr  out  32  word address to memory; bits [1:0] always 0
o_mem_wdata  out  32  lane-shifted write data
o_mem_bmask  out  4  byte lanes
o_mem_wren  out  1  write enable
i_mem_rdata  in  32  async read data for o_mem_addr
o_rsp_valid  out  1  one-cycle response pulse; no backpressure
o_rsp_err  out  1  illegal funct3, out-of-range, or misaligned with MISALIGNED_EN=0
o_rsp_rdata  out  32  extended load data; 0 for stores and errors

Behaviour:
- Reset (i_reset_n low at posedge) moves the FSM to IDLE. It also sets o_rsp_valid=0, o_rsp_err=0, o_rsp_rdata=0, o_mem_wren=0, o_mem_bmask=0 and o_mem_addr=0.
- States:
  - IDLE -> ACC0 on i_req_valid & o_req_ready. Request fields are registered at this edge; later changes to i_req_* are ignored.
  - IDLE -> RESP directly, with err=1, on error. No memory cycle is issued.
  - ACC0 -> ACC1 if the access crosses a word boundary (offset + size > 4); otherwise ACC0 -> RESP.
  - ACC1 -> RESP.
  - RESP -> IDLE.
- Size is 1/2/4 bytes from funct3[1:0]. The offset o is addr[1:0].
- Error conditions:
  - funct3 is 011, 110 or 111 for a load.
  - funct3[2]=1 for a store.
  - addr[31:ADDR_W] != 0.
  - A split access whose second word is addr + 4 >= 2^ADDR_W.
- ACC0 drives o_mem_addr = {addr[31:2],2'b00}, o_mem_bmask = (((1<<size)-1) << o)[3:0] and o_mem_wdata = wdata << 8*o. o_mem_wren equals store.
- ACC1 drives o_mem_addr = previous word + 4, o_mem_bmask = (((1<<size)-1) << o)[7:4] and o_mem_wdata = wdata >> 8*(4-o). o_mem_wren equals store.
- Outside ACC0/ACC1, o_mem_wren=0 and o_mem_bmask=0.
- Load capture: i_mem_rdata is captured at the end of ACC0 (lo) and ACC1 (hi; hi=0 if not split).
- Load result: raw = ({hi,lo} >> 8*o)[31:0]. LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
- RESP: o_rsp_valid=1 for exactly one cycle. o_rsp_err and o_rsp_rdata are valid in that cycle and return to 0 after it.
- Latency, counted from the accept edge T:
  - aligned access: response in cycle T+2
  - split access: response in cycle T+3
  - error: response in cycle T+1
- Throughput: a new request is accepted at the earliest in the cycle after RESP. o_req_ready is low in ACC0/ACC1/RESP.
- Reset mid-operation: the FSM aborts to IDLE and no response is issued. A split store interrupted after ACC0 leaves its first word written; this is acceptable and documented.
- Loads never assert o_mem_wren. Stores produce o_rsp_rdata=0.

Decomposition:
- lsu_pkg:
  - state enum (IDLE, ACC0, ACC1, RESP)
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101
  - size function
- One combinational sub-module, lsu_align: produces the two byte masks, the two shifted write words, and the extended load result from {hi,lo}, offset and funct3.

Test Plan:
- SW 0xDEADBEEF @0x010 -> T+1: addr=0x010, bmask=1111, wren=1, wdata=0xDEADBEEF; T+2: rsp_valid=1, err=0. Then LW @0x010 -> rdata=0xDEADBEEF.
- SB 0x000000A5 @0x023 -> bmask=1000, wdata=0xA5000000. Then LB @0x023 -> 0xFFFFFFA5; LBU -> 0x000000A5.
- SH 0x1234 @0x007 (split) -> ACC0: addr=0x004, bmask=1000, wdata[31:24]=0x34; ACC1: addr=0x008, bmask=0001, wdata[7:0]=0x12; rsp at T+3. Then LHU @0x007 -> 0x00001234.
- LW @0x1000, LW @0xFFE with word 0xFFC/0x000 boundary, and load funct3=011 -> each gives rsp_valid at T+1 with err=1, rdata=0 and no wren/bmask activity.
- With MISALIGNED_EN=0, LH @0x001 -> err=1. With MISALIGNED_EN=1, LH @0x001 (non-split) -> single access, rsp at T+2.
- i_reset_n low during ACC1 of a split store -> next cycle IDLE, o_req_ready=1, no rsp_valid, first word written, second word unchanged.
